regfile_move_scheduler: RTL and testbench
=========================================

Name: regfile_move_scheduler

Overview:
- Sequences register-to-register moves on the shared 8-bit tristate bus by driving the global r_addr/w_addr lines.
- Arbitrates NUM_REQ requesters round-robin and executes each granted request as a burst of 1..16 single-cycle moves.
- Each beat selects one source unit to drive the bus (r_addr) and one destination to capture it (w_addr).
- Register file occupies 0x00-0x0f; other units decode other address ranges; IDLE_ADDR selects nobody.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ), minimum 1.
- IDLE_ADDR, 8'hFF, address driven on r_addr/w_addr when no move is active; must decode to no unit.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request.
- src_addr  input  8*NUM_REQ  first source address; requester i uses bits [8i+7:8i].
- dst_addr  input  8*NUM_REQ  first destination address, same packing.
- len  input  4*NUM_REQ  beats minus 1 (0 = 1 beat, 15 = 16 beats), same packing at 4 bits.
- ack  output  NUM_REQ  one-cycle pulse: request accepted; coincides with first beat.
- done  output  NUM_REQ  one-cycle pulse during the last beat of the granted burst.
- busy  output  1  high while a burst is on the bus.
- grant_id  output  ID_W  index of current/last granted requester.
- r_addr  output  8  bus read-select address.
- w_addr  output  8  bus write-select address.

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: r_addr = w_addr = IDLE_ADDR; ack = 0; done = 0; busy = 0; grant_id = 0; round-robin pointer = 0; state = IDLE.
- rst has priority over all other events.
- States: IDLE, XFER.
- IDLE, req == 0: hold reset-like outputs; pointer unchanged.
- IDLE, req != 0: at the edge, grant g = first set req bit searching ptr, ptr+1, ... mod NUM_REQ. Then:
  - latch src/dst/len of g;
  - next cycle: r_addr = src, w_addr = dst, ack[g] = 1, busy = 1, grant_id = g;
  - done[g] = 1 in that same cycle if len == 0;
  - ptr <= (g+1) mod NUM_REQ; state <= XFER.
- XFER, each edge with remaining > 0: r_addr and w_addr each increment by 1 mod 256 (0xFF -> 0x00); remaining decrements. done[g] = 1 in the cycle whose beat has remaining == 0.
- XFER, edge with remaining == 0: state <= IDLE; r_addr/w_addr <= IDLE_ADDR; busy/ack/done <= 0.
- Latency: sampling edge to first beat is 1 cycle. Burst of N beats occupies N consecutive cycles.
- At least one IDLE cycle (both addresses IDLE_ADDR) separates bursts. This cycle is the mandatory bus turnaround, so no two drivers overlap.
- Destination write commits at the edge that ends each beat cycle; done therefore precedes the final write commit by that edge.
- req is sampled only in IDLE. Requester holds req and its fields stable until it sees ack. A req still high after ack is treated as a new request at the next IDLE.
- Fields are latched at grant; changes during a burst have no effect.
- Overlapping ranges are executed strictly beat by beat, each beat reading current contents. src == dst is legal (no-op rewrite).
- No address range checking: bursts may cross 0x0f into other units' ranges or wrap 0xFF -> 0x00.
- Reset mid-burst: burst abandoned with no done pulse; outputs at reset values from the next cycle; ptr = 0.

Test Plan:
- Reset -> r_addr = w_addr = 0xFF, busy = 0, ack = done = 0, held while req = 0.
- req[0] with src 0x02, dst 0x05, len 0 -> next cycle r = 0x02, w = 0x05, ack[0] = done[0] = 1, busy = 1; following cycle 0xFF/0xFF; register 5 equals old register 2.
- req[1] with src 0x00, dst 0x08, len 3 -> beats (00,08), (01,09), (02,0A), (03,0B); ack on beat 1 only, done on beat 4 only; then IDLE.
- req = 4'b1111 held continuously, all len 0 -> grant_id sequence 0, 1, 2, 3, 0, each burst separated by exactly one 0xFF idle cycle.
- src 0xFE, dst 0x0E, len 2 -> beats (FE,0E), (FF,0F), (00,10); wrap at 0xFF, no stall.
- rst asserted on beat 2 of a len-7 burst -> next cycle addresses 0xFF, no done pulse; subsequent req[2] with req[0] also pending grants 0 first (ptr reset).

Source files
------------

// File: rtl/regfile_move_scheduler_if.sv
// Requester/bus bundle for regfile_move_scheduler: request fields in,
// bus select addresses and handshake pulses out.
interface regfile_move_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] src_addr;
  logic [8*NUM_REQ-1:0] dst_addr;
  logic [4*NUM_REQ-1:0] len;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   done;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;
  logic [7:0]           r_addr;
  logic [7:0]           w_addr;

  modport master (
    output req, src_addr, dst_addr, len,
    input  ack, done, busy, grant_id, r_addr, w_addr
  );

  modport slave (
    input  req, src_addr, dst_addr, len,
    output ack, done, busy, grant_id, r_addr, w_addr
  );
endinterface

// File: rtl/regfile_move_scheduler.sv
// Round-robin scheduler for register-to-register bursts on the shared
// tristate bus; drives r_addr/w_addr one move per cycle.
module regfile_move_scheduler #(
  parameter int         NUM_REQ   = 4,
  parameter logic [7:0] IDLE_ADDR = 8'hFF
) (
  input logic                     clk,
  input logic                     rst,
  regfile_move_scheduler_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t               state, state_n;
  logic [ID_W-1:0]      ptr, ptr_n;
  logic [ID_W-1:0]      grant_id_q, grant_id_n;
  logic [3:0]           remaining, remaining_n;
  logic [7:0]           r_q, r_n, w_q, w_n;
  logic [NUM_REQ-1:0]   ack_q, ack_n, done_q, done_n;
  logic                 busy_q, busy_n;

  logic                 found;
  logic [ID_W-1:0]      g, g_next;
  logic [ID_W:0]        idx_w;
  logic [7:0]           src_sel, dst_sel;
  logic [3:0]           len_sel;
  logic [NUM_REQ-1:0]   g_onehot, cur_onehot;

  // Round-robin search starting at ptr; the selected requester's fields are
  // muxed out alongside so the grant cycle can load them straight into the
  // address registers.
  always_comb begin
    found   = 1'b0;
    g       = '0;
    idx_w   = '0;
    src_sel = '0;
    dst_sel = '0;
    len_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_w = {1'b0, ptr} + (ID_W+1)'(i);
      if (idx_w >= (ID_W+1)'(NUM_REQ)) idx_w = idx_w - (ID_W+1)'(NUM_REQ);
      if (!found && bus.req[idx_w[ID_W-1:0]]) begin
        found = 1'b1;
        g     = idx_w[ID_W-1:0];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (g == ID_W'(i)) begin
        src_sel = bus.src_addr[8*i +: 8];
        dst_sel = bus.dst_addr[8*i +: 8];
        len_sel = bus.len[4*i +: 4];
      end
    end
  end

  always_comb begin
    g_next     = (g == ID_W'(NUM_REQ-1)) ? '0 : g + 1'b1;
    g_onehot   = '0;
    cur_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (g == ID_W'(i))          g_onehot[i]   = 1'b1;
      if (grant_id_q == ID_W'(i)) cur_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    grant_id_n  = grant_id_q;
    remaining_n = remaining;
    r_n         = IDLE_ADDR;
    w_n         = IDLE_ADDR;
    ack_n       = '0;
    done_n      = '0;
    busy_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n     = XFER;
          ptr_n       = g_next;
          grant_id_n  = g;
          remaining_n = len_sel;
          r_n         = src_sel;
          w_n         = dst_sel;
          ack_n       = g_onehot;
          done_n      = (len_sel == 4'd0) ? g_onehot : '0;
          busy_n      = 1'b1;
        end
      end
      XFER: begin
        // remaining counts beats still to come after the one on the bus now;
        // reaching zero here means the final beat just ended.
        if (remaining != 4'd0) begin
          remaining_n = remaining - 4'd1;
          r_n         = r_q + 8'd1;
          w_n         = w_q + 8'd1;
          done_n      = (remaining == 4'd1) ? cur_onehot : '0;
          busy_n      = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      grant_id_q <= '0;
      remaining  <= '0;
      r_q        <= IDLE_ADDR;
      w_q        <= IDLE_ADDR;
      ack_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      grant_id_q <= grant_id_n;
      remaining  <= remaining_n;
      r_q        <= r_n;
      w_q        <= w_n;
      ack_q      <= ack_n;
      done_q     <= done_n;
      busy_q     <= busy_n;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;
  assign bus.r_addr   = r_q;
  assign bus.w_addr   = w_q;
endmodule

// File: tb/tb_regfile_move_scheduler.sv
// Scoreboard bench for regfile_move_scheduler: directed bursts push expected
// beats; a negedge monitor pops and compares every bus cycle.
module tb_regfile_move_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_move_scheduler_if #(.NUM_REQ(4)) bus ();

  regfile_move_scheduler #(.NUM_REQ(4), .IDLE_ADDR(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // expected beat: {r_addr, w_addr, ack, done, grant_id}
  logic [25:0] exp_q[$];
  int          gap_q[$];
  int n_vec_mon = 0, n_err_mon = 0;
  int n_vec_drv = 0, n_err_drv = 0;
  int idle_run  = 0;
  bit mon_en    = 1'b0;

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (bus.busy) begin
      mem[bus.w_addr] <= mem[bus.r_addr];
    end
  end

  always @(negedge clk) begin
    logic [25:0] act, e;
    int gp;
    if (mon_en) begin
      act = {bus.r_addr, bus.w_addr, bus.ack, bus.done, bus.grant_id};
      if (bus.busy) begin
        n_vec_mon++;
        if (exp_q.size() == 0) begin
          n_err_mon++;
          $display("FAIL unexpected_beat: got r=%h w=%h ack=%b done=%b gid=%0d, required no beat",
                   bus.r_addr, bus.w_addr, bus.ack, bus.done, bus.grant_id);
        end else begin
          e  = exp_q.pop_front();
          gp = gap_q.pop_front();
          if (act !== e) begin
            n_err_mon++;
            $display("FAIL beat: got r=%h w=%h ack=%b done=%b gid=%0d, required r=%h w=%h ack=%b done=%b gid=%0d",
                     act[25:18], act[17:10], act[9:6], act[5:2], act[1:0],
                     e[25:18], e[17:10], e[9:6], e[5:2], e[1:0]);
          end
          if (gp >= 0) begin
            n_vec_mon++;
            if (idle_run != gp) begin
              n_err_mon++;
              $display("FAIL idle_gap: got %0d idle cycles, required %0d", idle_run, gp);
            end
          end
        end
        idle_run = 0;
      end else begin
        idle_run++;
        n_vec_mon++;
        if ({bus.r_addr, bus.w_addr, bus.ack, bus.done} !== {8'hFF, 8'hFF, 4'h0, 4'h0}) begin
          n_err_mon++;
          $display("FAIL idle_outputs: got r=%h w=%h ack=%b done=%b, required r=ff w=ff ack=0000 done=0000",
                   bus.r_addr, bus.w_addr, bus.ack, bus.done);
        end
      end
    end
  end

  task automatic push(input logic [7:0] r, input logic [7:0] w, input logic [3:0] a,
                      input logic [3:0] d, input logic [1:0] gid, input int gap);
    exp_q.push_back({r, w, a, d, gid});
    gap_q.push_back(gap);
  endtask

  task automatic set_field(input int i, input logic [7:0] s, input logic [7:0] d, input logic [3:0] l);
    bus.src_addr[8*i +: 8] = s;
    bus.dst_addr[8*i +: 8] = d;
    bus.len[4*i +: 4]      = l;
  endtask

  // Raises req[mask], waits for n_acks acceptances; hold keeps acked bits up.
  task automatic issue(input logic [3:0] mask, input int n_acks, input bit hold);
    int got = 0;
    int budget = 0;
    logic [3:0] pend = mask;
    bus.req = mask;
    while (got < n_acks && budget < 200) begin
      @(posedge clk); #1;
      budget++;
      if (|(bus.ack & pend)) begin
        got++;
        if (!hold) pend = pend & ~bus.ack;
      end
      bus.req = pend;
    end
    bus.req = '0;
    n_vec_drv++;
    if (got < n_acks) begin
      n_err_drv++;
      $display("FAIL ack_timeout: got %0d acks, required %0d", got, n_acks);
    end
  endtask

  task automatic drain();
    int budget = 0;
    while ((exp_q.size() != 0 || bus.busy) && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    @(posedge clk); #1;
    n_vec_drv++;
    if (exp_q.size() != 0) begin
      n_err_drv++;
      $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.req = '0; bus.src_addr = '0; bus.dst_addr = '0; bus.len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    n_vec_drv++;
    if (bus.grant_id !== 2'd0 || bus.busy !== 1'b0) begin
      n_err_drv++;
      $display("FAIL reset_state: got gid=%0d busy=%b, required gid=0 busy=0", bus.grant_id, bus.busy);
    end
    repeat (3) @(posedge clk); #1;

    // single beat, ack and done together
    set_field(0, 8'h02, 8'h05, 4'd0);
    push(8'h02, 8'h05, 4'b0001, 4'b0001, 2'd0, -1);
    issue(4'b0001, 1, 1'b0);
    drain();
    n_vec_drv++;
    if (mem[5] !== 8'hA7 || mem[2] !== 8'hA7) begin
      n_err_drv++;
      $display("FAIL move_data: got reg5=%h reg2=%h, required a7 a7", mem[5], mem[2]);
    end

    // four-beat burst
    set_field(1, 8'h00, 8'h08, 4'd3);
    push(8'h00, 8'h08, 4'b0010, 4'b0000, 2'd1, -1);
    push(8'h01, 8'h09, 4'b0000, 4'b0000, 2'd1, 0);
    push(8'h02, 8'h0A, 4'b0000, 4'b0000, 2'd1, 0);
    push(8'h03, 8'h0B, 4'b0000, 4'b0010, 2'd1, 0);
    issue(4'b0010, 1, 1'b0);
    drain();

    // all requesting, held: rotation 0,1,2,3,0 with one idle each
    pulse_reset();
    for (int i = 0; i < 4; i++) set_field(i, 8'h10 + 8'(i), 8'h20 + 8'(i), 4'd0);
    push(8'h10, 8'h20, 4'b0001, 4'b0001, 2'd0, -1);
    push(8'h11, 8'h21, 4'b0010, 4'b0010, 2'd1, 1);
    push(8'h12, 8'h22, 4'b0100, 4'b0100, 2'd2, 1);
    push(8'h13, 8'h23, 4'b1000, 4'b1000, 2'd3, 1);
    push(8'h10, 8'h20, 4'b0001, 4'b0001, 2'd0, 1);
    issue(4'b1111, 5, 1'b1);
    drain();

    // address wrap at 0xFF
    set_field(3, 8'hFE, 8'h0E, 4'd2);
    push(8'hFE, 8'h0E, 4'b1000, 4'b0000, 2'd3, -1);
    push(8'hFF, 8'h0F, 4'b0000, 4'b0000, 2'd3, 0);
    push(8'h00, 8'h10, 4'b0000, 4'b1000, 2'd3, 0);
    issue(4'b1000, 1, 1'b0);
    drain();

    // reset on beat 2 of a len-7 burst; pointer returns to 0
    set_field(1, 8'h30, 8'h40, 4'd7);
    push(8'h30, 8'h40, 4'b0010, 4'b0000, 2'd1, -1);
    push(8'h31, 8'h41, 4'b0000, 4'b0000, 2'd1, 0);
    issue(4'b0010, 1, 1'b0);
    @(posedge clk); #1;
    pulse_reset();
    repeat (2) @(posedge clk); #1;
    set_field(0, 8'h50, 8'h60, 4'd0);
    set_field(2, 8'h70, 8'h80, 4'd1);
    push(8'h50, 8'h60, 4'b0001, 4'b0001, 2'd0, -1);
    push(8'h70, 8'h80, 4'b0100, 4'b0000, 2'd2, 1);
    push(8'h71, 8'h81, 4'b0000, 4'b0100, 2'd2, 0);
    issue(4'b0101, 2, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec_mon + n_vec_drv, n_err_mon + n_err_drv);
    $finish;
  end
endmodule
